fa_bh: RTL and testbench

FA_BH -- requirements
Module: fa_bh

---
 rtl/fa_bh_pkg.sv | 16 +
 rtl/fa_bh_core.sv | 11 +
 rtl/fa_bh.sv | 73 +++++++
 tb/tb_fa_bh.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fa_bh_pkg.sv
// fa_bh_pkg: shared limits, stage record and saturating counter helper for fa_bh
package fa_bh_pkg;
    localparam int PIPE_MIN = 1;
    localparam int PIPE_MAX = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic v;
        logic s;
        logic c;
    } stage_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction
endpackage

// File: rtl/fa_bh_core.sv
// fa_core: combinational one-bit full adder
module fa_core (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/fa_bh.sv
// fa_bh: pipelined full adder with optional bit-serial carry feedback and bit counter
module fa_bh
    import fa_bh_pkg::*;
#(
    parameter int PIPE_STAGES = 1,
    parameter bit SERIAL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             Cout,
    input  logic             in_valid,
    input  logic             serial_mode,
    input  logic             serial_start,
    output logic             sum,
    output logic             carry,
    output logic             out_valid,
    output logic             sum_comb,
    output logic             carry_comb,
    output logic [CNT_W-1:0] serial_cnt
);
    localparam int NS = (PIPE_STAGES < PIPE_MIN) ? PIPE_MIN :
                        (PIPE_STAGES > PIPE_MAX) ? PIPE_MAX : PIPE_STAGES;

    logic   serial_on;
    logic   cin;
    logic   carry_fb;
    stage_t stg [NS];

    assign serial_on = SERIAL_EN && serial_mode;
    assign cin = (serial_on && !serial_start) ? carry_fb : Cout;

    fa_core u_core (
        .a  (a),
        .b  (b),
        .cin(cin),
        .s  (sum_comb),
        .co (carry_comb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_fb   <= 1'b0;
            serial_cnt <= '0;
        end else if (in_valid && serial_on) begin
            carry_fb   <= carry_comb;
            serial_cnt <= serial_start ? CNT_W'(1) : sat_inc(serial_cnt);
        end
    end

    // valid shifts every cycle; data only moves alongside a valid bit
    for (genvar i = 0; i < NS; i++) begin : g_stage
        stage_t prev;
        if (i == 0) begin : g_in
            assign prev = '{v: in_valid, s: sum_comb, c: carry_comb};
        end else begin : g_chain
            assign prev = stg[i-1];
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stg[i] <= '0;
            end else begin
                stg[i].v <= prev.v;
                if (prev.v) {stg[i].s, stg[i].c} <= {prev.s, prev.c};
            end
        end
    end

    assign out_valid = stg[NS-1].v;
    assign sum       = stg[NS-1].s;
    assign carry     = stg[NS-1].c;
endmodule

// File: tb/tb_fa_bh.sv
// tb_fa_bh: directed checks of fa_bh at several pipeline depths and serial settings
module tb_fa_bh;
    logic clk = 0;
    logic rst_n, a, b, cin_x, in_valid, serial_mode, serial_start;
    logic sum_o [4], carry_o [4], ov_o [4], sc_o [4], cc_o [4];
    logic [7:0] cnt_o [4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fa_bh #(.PIPE_STAGES(1), .SERIAL_EN(0)) d0 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cout(cin_x),
        .in_valid(in_valid), .serial_mode(serial_mode), .serial_start(serial_start), .sum(sum_o[0]),
        .carry(carry_o[0]), .out_valid(ov_o[0]), .sum_comb(sc_o[0]), .carry_comb(cc_o[0]), .serial_cnt(cnt_o[0]));
    fa_bh #(.PIPE_STAGES(1), .SERIAL_EN(1)) d1 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cout(cin_x),
        .in_valid(in_valid), .serial_mode(serial_mode), .serial_start(serial_start), .sum(sum_o[1]),
        .carry(carry_o[1]), .out_valid(ov_o[1]), .sum_comb(sc_o[1]), .carry_comb(cc_o[1]), .serial_cnt(cnt_o[1]));
    fa_bh #(.PIPE_STAGES(2), .SERIAL_EN(1)) d2 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cout(cin_x),
        .in_valid(in_valid), .serial_mode(serial_mode), .serial_start(serial_start), .sum(sum_o[2]),
        .carry(carry_o[2]), .out_valid(ov_o[2]), .sum_comb(sc_o[2]), .carry_comb(cc_o[2]), .serial_cnt(cnt_o[2]));
    fa_bh #(.PIPE_STAGES(3), .SERIAL_EN(1)) d3 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cout(cin_x),
        .in_valid(in_valid), .serial_mode(serial_mode), .serial_start(serial_start), .sum(sum_o[3]),
        .carry(carry_o[3]), .out_valid(ov_o[3]), .sum_comb(sc_o[3]), .carry_comb(cc_o[3]), .serial_cnt(cnt_o[3]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic vc, input logic vv,
                         input logic vm, input logic vs);
        a = va; b = vb; cin_x = vc; in_valid = vv; serial_mode = vm; serial_start = vs;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] es, ec;
        es = 8'b1001_0110;
        ec = 8'b1110_1000;
        rst_n = 0;
        drive(1, 0, 1, 1, 0, 0);
        chk("rst_comb_sum", {7'd0, sc_o[1]}, 8'd0);
        chk("rst_comb_carry", {7'd0, cc_o[1]}, 8'd1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_out%0d", k), {5'd0, ov_o[k], sum_o[k], carry_o[k]}, 8'd0);
            chk($sformatf("rst_cnt%0d", k), cnt_o[k], 8'd0);
        end
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            drive(i[2], i[1], i[0], 1, 0, 0);
            chk($sformatf("tt_comb%0d", i), {6'd0, sc_o[1], cc_o[1]}, {6'd0, es[i], ec[i]});
            tick();
            chk($sformatf("tt_reg%0d", i), {5'd0, ov_o[1], sum_o[1], carry_o[1]}, {5'd0, 1'b1, es[i], ec[i]});
            if (i > 0) chk($sformatf("tt_ps2_%0d", i), {5'd0, ov_o[2], sum_o[2], carry_o[2]},
                           {5'd0, 1'b1, es[i-1], ec[i-1]});
        end
        idle(4);
        chk("idle_hold", {6'd0, sum_o[1], carry_o[1]}, 8'b11);

        drive(0, 1, 0, 1, 0, 0);
        tick();
        drive(1, 1, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("lat_e1", {7'd0, ov_o[3]}, 8'd1);
        chk("lat_e1_data", {6'd0, sum_o[3], carry_o[3]}, 8'b10);
        tick();
        chk("lat_e2", {7'd0, ov_o[3]}, 8'd1);
        chk("lat_e2_data", {6'd0, sum_o[3], carry_o[3]}, 8'b11);
        tick();
        chk("lat_e3", {7'd0, ov_o[3]}, 8'd0);
        tick();
        chk("lat_hold", {5'd0, ov_o[3], sum_o[3], carry_o[3]}, 8'b011);

        drive(1, 1, 0, 1, 1, 1);
        tick();
        chk("ser_b0", {6'd0, sum_o[1], carry_o[1]}, 8'b01);
        chk("ser_cnt1", cnt_o[1], 8'd1);
        drive(0, 1, 0, 1, 1, 0);
        chk("ser_b1_comb", {6'd0, sc_o[1], cc_o[1]}, 8'b01);
        chk("ser_off_comb", {6'd0, sc_o[0], cc_o[0]}, 8'b10);
        tick();
        chk("ser_b1", {6'd0, sum_o[1], carry_o[1]}, 8'b01);
        chk("ser_off_cnt", cnt_o[0], 8'd0);
        drive(1, 0, 0, 1, 1, 0);
        tick();
        chk("ser_b2", {6'd0, sum_o[1], carry_o[1]}, 8'b01);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("ser_b3", {6'd0, sum_o[1], carry_o[1]}, 8'b10);
        chk("ser_cnt4", cnt_o[1], 8'd4);

        drive(1, 1, 0, 1, 1, 1);
        tick();
        drive(0, 0, 1, 0, 1, 0);
        tick();
        tick();
        chk("gap_hold", {5'd0, ov_o[1], sum_o[1], carry_o[1]}, 8'b001);
        chk("gap_cnt", cnt_o[1], 8'd1);
        drive(1, 0, 0, 1, 1, 0);
        chk("gap_fb_comb", {6'd0, sc_o[1], cc_o[1]}, 8'b01);
        tick();
        chk("gap_cnt2", cnt_o[1], 8'd2);
        drive(0, 0, 0, 1, 0, 1);
        tick();
        chk("mode0_sum", {6'd0, sum_o[1], carry_o[1]}, 8'b00);
        chk("mode0_start_ign", cnt_o[1], 8'd2);
        drive(0, 0, 0, 1, 1, 0);
        chk("fb_retained", {6'd0, sc_o[1], cc_o[1]}, 8'b10);
        tick();
        chk("cnt3", cnt_o[1], 8'd3);

        repeat (260) tick();
        chk("cnt_sat", cnt_o[1], 8'd255);

        idle(4);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        chk("rmf_out", {5'd0, ov_o[2], sum_o[2], carry_o[2]}, 8'd0);
        chk("rmf_cnt", cnt_o[2], 8'd0);
        chk("rmf_d1", {5'd0, ov_o[1], sum_o[1], carry_o[1]}, 8'd0);
        rst_n = 1;
        tick();
        chk("rmf_after", {5'd0, ov_o[2], sum_o[2], carry_o[2]}, 8'd0);
        tick();
        chk("rmf_after2", {7'd0, ov_o[2]}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
